// File: rtl/mac16_seq_if.sv
// mac16_seq_if: start/ready/done handshake and operand/result bus for mac16_seq
interface mac16_seq_if #(parameter int MUL_W = 16);
    logic             start;
    logic             ready;
    logic [MUL_W-1:0] mcand;
    logic [MUL_W-1:0] mplier;
    logic [31:0]      acc_in;
    logic             accum;
    logic [31:0]      result;
    logic             done;
    logic             ovf;

    modport master (output start, mcand, mplier, acc_in, accum, input ready, result, done, ovf);
    modport slave  (input start, mcand, mplier, acc_in, accum, output ready, result, done, ovf);
endinterface

// File: rtl/mac16_seq.sv
// mac16_seq: sequential multiply-accumulate, two multiplier bits per clock via one 3-operand adder; MAC16_SEQ_SAT_EN saturates result on overflow
module mac16_seq #(
    parameter int MUL_W = 16
) (
    input logic        clk,
    input logic        resetl,
    mac16_seq_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam int CW = $clog2(MUL_W / 2 + 1);
    localparam logic [CW-1:0] LAST = CW'(MUL_W / 2 - 1);

    logic [1:0]       state;
    logic [CW-1:0]    count;
    logic [MUL_W-1:0] mcand_r;
    logic [MUL_W-1:0] mplier_r;
    logic [31:0]      acc;
    logic [31:0]      result;
    logic             ovf;
    logic [4:0]       sh0;
    logic [4:0]       sh1;
    logic             bit0;
    logic             bit1;
    logic [31:0]      mc_ext;
    logic [31:0]      op_b;
    logic [31:0]      op_c;
    logic [33:0]      sum;
    logic             ovf_n;
    logic [31:0]      res_n;

    assign bus.ready  = state == IDLE;
    assign bus.done   = state == DONE;
    assign bus.result = result;
    assign bus.ovf    = ovf;

    // adder pass for step k: acc + partial products of multiplier bits 2k and 2k+1
    always_comb begin
        sh0    = 5'({count, 1'b0});
        sh1    = 5'({count, 1'b1});
        bit0   = |(mplier_r & (MUL_W'(1) << sh0));
        bit1   = |(mplier_r & (MUL_W'(1) << sh1));
        mc_ext = 32'(mcand_r);
        op_b   = bit0 ? mc_ext << sh0 : '0;
        op_c   = bit1 ? mc_ext << sh1 : '0;
        sum    = 34'(acc) + 34'(op_b) + 34'(op_c);
        ovf_n  = ovf | sum[32] | sum[33];
`ifdef MAC16_SEQ_SAT_EN
        res_n  = ovf_n ? 32'hFFFF_FFFF : sum[31:0];
`else
        res_n  = sum[31:0];
`endif
    end

    // IDLE accepts operands, RUN retires two bits per edge, DONE presents result for one cycle
    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            state    <= IDLE;
            count    <= '0;
            mcand_r  <= '0;
            mplier_r <= '0;
            acc      <= '0;
            result   <= '0;
            ovf      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    mcand_r  <= bus.mcand;
                    mplier_r <= bus.mplier;
                    acc      <= bus.accum ? bus.acc_in : '0;
                    ovf      <= 1'b0;
                    count    <= '0;
                    state    <= RUN;
                end
                RUN: begin
                    acc <= sum[31:0];
                    ovf <= ovf_n;
                    if (count == LAST) begin
                        result <= res_n;
                        state  <= DONE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mac16_seq.sv
// tb_mac16_seq: table-driven scoreboard bench for mac16_seq (honours MAC16_SEQ_SAT_EN)
module tb_mac16_seq;
    logic clk = 1'b0;
    logic resetl = 1'b0;
    always #5 clk = ~clk;

    mac16_seq_if #(.MUL_W(16)) bus();
    mac16_seq #(.MUL_W(16)) dut (.clk(clk), .resetl(resetl), .bus(bus));

    typedef struct {
        logic [15:0] mc;
        logic [15:0] mp;
        logic [31:0] ai;
        logic        ac;
        logic [31:0] er;
        logic        eo;
    } vec_t;
    typedef struct {
        logic [31:0] r;
        logic        o;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;
    vec_t tbl[12];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [32:0] model(input logic [15:0] mc, input logic [15:0] mp,
                                          input logic [31:0] ai, input logic ac);
        logic [63:0] s;
        logic        o;
        logic [31:0] r;
        s = (ac ? {32'b0, ai} : 64'b0) + 64'(mc) * 64'(mp);
        o = s[63:32] != 0;
        r = s[31:0];
`ifdef MAC16_SEQ_SAT_EN
        if (o) r = 32'hFFFF_FFFF;
`endif
        return {o, r};
    endfunction

    always @(negedge clk) begin
        check("ready_done_excl", 32'(bus.ready & bus.done), 32'd0);
        if (bus.done) begin
            if (sbq.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = sbq.pop_front();
                check("result", bus.result, mon_e.r);
                check("ovf", 32'(bus.ovf), 32'(mon_e.o));
                check("latency", 32'(cyc - t0), 32'd8);
            end
        end
    end

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.done && n < 30);
        if (!bus.done) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_op(input vec_t v);
        int n = 0;
        @(negedge clk);
        while (!bus.ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (!bus.ready) check("ready_timeout", 32'd0, 32'd1);
        bus.start  = 1'b1;
        bus.mcand  = v.mc;
        bus.mplier = v.mp;
        bus.acc_in = v.ai;
        bus.accum  = v.ac;
        sbq.push_back('{v.er, v.eo});
        @(posedge clk);
        #1 t0 = cyc;
        bus.start = 1'b0;
        bus.mcand = $urandom;
        bus.mplier = $urandom;
        bus.acc_in = $urandom;
        wait_done();
        @(negedge clk);
        check("ready_after_done", 32'(bus.ready), 32'd1);
        check("done_one_cycle", 32'(bus.done), 32'd0);
        check("result_held", bus.result, v.er);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.mcand = '0;
        bus.mplier = '0;
        bus.acc_in = '0;
        bus.accum = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_result", bus.result, 32'd0);
        check("rst_ovf", 32'(bus.ovf), 32'd0);
        resetl = 1'b1;

        tbl[0] = '{16'h0003, 16'h0005, 32'h0000_0000, 1'b0, 32'h0000_000F, 1'b0};
        tbl[1] = '{16'hFFFF, 16'hFFFF, 32'h0000_0000, 1'b0, 32'hFFFE_0001, 1'b0};
        tbl[2] = '{16'h1234, 16'h0010, 32'h0000_0010, 1'b1, 32'h0001_2350, 1'b0};
`ifdef MAC16_SEQ_SAT_EN
        tbl[3] = '{16'h0002, 16'h0001, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};
`else
        tbl[3] = '{16'h0002, 16'h0001, 32'hFFFF_FFFF, 1'b1, 32'h0000_0001, 1'b1};
`endif
        tbl[4] = '{16'hFFFF, 16'hFFFF, 32'h0001_FFFF, 1'b1, 32'h0000_0000, 1'b0};
        tbl[5] = '{16'h0000, 16'hABCD, 32'h1234_5678, 1'b0, 32'h0000_0000, 1'b0};
        for (int i = 6; i < 12; i++) begin
            tbl[i].mc = 16'($urandom);
            tbl[i].mp = 16'($urandom);
            tbl[i].ai = (i % 2 == 0) ? 32'hFFF0_0000 | 32'($urandom_range(0, 65535)) : $urandom;
            tbl[i].ac = (i != 7);
        end
        for (int i = 4; i < 12; i++)
            {tbl[i].eo, tbl[i].er} = model(tbl[i].mc, tbl[i].mp, tbl[i].ai, tbl[i].ac);
        for (int i = 0; i < 12; i++) run_op(tbl[i]);

        @(negedge clk);
        bus.start  = 1'b1;
        bus.mcand  = 16'h0003;
        bus.mplier = 16'h0005;
        bus.accum  = 1'b0;
        sbq.push_back('{32'h0000_000F, 1'b0});
        @(posedge clk);
        #1 t0 = cyc;
        bus.mcand  = 16'h00FF;
        bus.mplier = 16'h00FF;
        wait_done();
        sbq.push_back('{32'h0000_FE01, 1'b0});
        @(posedge clk);
        @(posedge clk);
        #1 t0 = cyc;
        bus.start = 1'b0;
        check("second_accept", 32'(bus.ready), 32'd0);
        repeat (3) @(negedge clk);
        check("result_held_in_run", bus.result, 32'h0000_000F);
        wait_done();

        @(negedge clk);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.mcand  = 16'h1234;
        bus.mplier = 16'h5678;
        sbq.push_back('{32'h0, 1'b0});
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2 resetl = 1'b0;
        #1;
        sbq.delete();
        check("midrst_ready", 32'(bus.ready), 32'd1);
        check("midrst_done", 32'(bus.done), 32'd0);
        check("midrst_result", bus.result, 32'd0);
        check("midrst_ovf", 32'(bus.ovf), 32'd0);
        repeat (2) @(negedge clk);
        resetl = 1'b1;
        repeat (12) @(negedge clk);
        run_op('{16'h0007, 16'h0009, 32'h0, 1'b0, 32'h0000_003F, 1'b0});

        check("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mac16_seq.md
Name: mac16_seq

Overview:
- Multi-cycle multiply-accumulate sequencer built around one shared 32-bit three-operand adder (two carry inputs, two carry outputs).
- Computes result = (accum ? acc_in : 0) + mcand * mplier, unsigned, retiring two multiplier bits per clock.
- Used where a full-array multiplier is too costly, e.g. address scaling and blitter/DSP helper arithmetic.
- Start/ready/done handshake; result held until the next accepted start.

Parameters:
- MUL_W, 16: multiplier and multiplicand width. Even, 2..16. Iterations = MUL_W/2.

Ports:
- clk  in  1  system clock, all state on rising edge
- resetl  in  1  asynchronous active-low reset
- start  in  1  request; accepted only on an edge where ready=1
- ready  out  1  high in IDLE
- mcand  in  MUL_W  multiplicand, latched on accept
- mplier  in  MUL_W  multiplier, latched on accept
- acc_in  in  32  accumulator seed, latched on accept
- accum  in  1  1 = seed acc from acc_in, 0 = seed 0; latched on accept
- result  out  32  registered result; valid from done, held until next accept
- done  out  1  one-cycle pulse, result valid
- ovf  out  1  sticky per operation: carry out of bit 31 seen; valid with done

Behaviour:
- Reset (resetl=0, asynchronous): state=IDLE, step count=0, acc=0, result=0, done=0, ovf=0, ready=1. Applies mid-RUN; the operation is abandoned with no done pulse.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - ready=1.
  - Edge with start=1: latch mcand, mplier and accum; acc <= accum ? acc_in : 0; ovf <= 0; count <= 0; go to RUN.
- RUN, one adder pass per edge, k = count:
  - operand a = acc.
  - operand b = mplier[2k] ? (mcand << 2k) : 0, zero-extended to 32 bits.
  - operand c = mplier[2k+1] ? (mcand << (2k+1)) : 0, zero-extended to 32 bits.
  - ci0 = ci1 = 0.
  - acc <= 32-bit sum; ovf <= ovf | co0 | co1.
  - After the pass with count = MUL_W/2 - 1, go to DONE. Otherwise count <= count + 1.
- DONE:
  - Entered with result <= final acc (see Optional Feature) and done=1 for exactly this cycle.
  - Next edge returns to IDLE.
- Latency: accept edge E0, RUN passes on E1..E(MUL_W/2), done=1 after that edge. Default MUL_W=16: done 8 clocks after E0, ready=1 again after E9.
- start while ready=0 (RUN or DONE) is ignored; latched operands are unaffected. No back-to-back accept in DONE.
- Arithmetic: sums are modulo 2^32. With accum=0 no carry-out can occur, so ovf=0. With accum=1, ovf=1 iff the true sum >= 2^32.
- Input ports are don't-care outside the accept edge.
- ready and done are never high together.

Optional Feature:
- Macro MAC16_SEQ_SAT_EN.
- Defined: at DONE entry, if ovf=1 then result <= 32'hFFFFFFFF; else result <= acc.
- Undefined: result <= acc, a wrapped modulo 2^32 value. ovf is reported identically in both builds.

Test Plan:
- Small product: mcand=0x0003, mplier=0x0005, accum=0 -> done exactly 8 clocks after accept; result=0x0000000F, ovf=0; ready=1 one clock later.
- Full-scale product: mcand=0xFFFF, mplier=0xFFFF, accum=0 -> result=0xFFFE0001, ovf=0.
- Accumulate: accum=1, acc_in=0x00000010, mcand=0x1234, mplier=0x0010 -> result=0x00012350, ovf=0.
- Overflow: accum=1, acc_in=0xFFFFFFFF, mcand=0x0002, mplier=0x0001 -> ovf=1. result=0x00000001 without MAC16_SEQ_SAT_EN; result=0xFFFFFFFF with it.
- Ignored start: accept 0x0003*0x0005, then hold start=1 with mcand=0x00FF, mplier=0x00FF through RUN and DONE -> first done shows 0x0000000F. A second accept occurs only on the edge after returning to IDLE and yields 0x0000FE01.
- Reset mid-op: pull resetl low during RUN pass 4 -> result=0, done=0, ovf=0, ready=1 immediately, no done pulse. After release, 0x0007*0x0009 -> result=0x0000003F.
